// File: rtl/qu_rob_pkg.sv
// qu_rob_pkg: shared ROB types and constants for the Qu core.
//   - Default ROB geometry (ROB_DEPTH, ROB_ADDR_WIDTH, ROB_NUM_WB).
//   - Entry state encoding (ROB_STATE_*), dest_t, default-width rob_cell_t
//     and rob_wb_t records.
//   - rob_retirable(): true when a state may leave through the retire port.
package qu_rob_pkg;

    localparam int ROB_DEPTH      = 8;
    localparam int ROB_ADDR_WIDTH = $clog2(ROB_DEPTH);
    localparam int ROB_NUM_WB     = 2;
    localparam int ROB_VALUE_W    = 32;
    localparam int ROB_PC_W       = 12;
    localparam int ROB_PREG_W     = 7;

    // Shared entry state encoding. RETIRED is reserved and never written.
    localparam logic [1:0] ROB_STATE_EMPTY   = 2'b00;
    localparam logic [1:0] ROB_STATE_RETIRED = 2'b01;
    localparam logic [1:0] ROB_STATE_EXECUTE = 2'b10;
    localparam logic [1:0] ROB_STATE_PENDING = 2'b11;

    // Physical register (zero padded) or DMEM address.
    typedef logic [31:0] dest_t;

    // Default-width cell; the ROB declares its own copy sized by its parameters.
    typedef struct packed {
        logic [1:0]             state;
        logic [ROB_VALUE_W-1:0] value;
        dest_t                  dest;
        logic [ROB_PREG_W-1:0]  phyreg_old;
        logic                   load;
        logic                   store;
        logic [2:0]             funct3;
        logic                   mispredicted_branch;
        logic [ROB_PC_W-1:0]    pc_new;
    } rob_cell_t;

    typedef struct packed {
        logic [ROB_ADDR_WIDTH-1:0] addr;
        logic [ROB_VALUE_W-1:0]    value;
        logic                      mispredict;
        logic [ROB_PC_W-1:0]       pc_new;
    } rob_wb_t;

    function automatic logic rob_retirable(input logic [1:0] state);
        return state == ROB_STATE_EXECUTE;
    endfunction

endpackage

// File: rtl/qu_rob_wb_merge.sv
// qu_rob_wb_merge: folds NUM_WB write-back ports into per-entry write
// enables and data. Purely combinational.
//   wb_*     : flattened port inputs (port i occupies slice i)
//   we       : per-entry write strobe
//   value / mispredict / pc_new : per-entry data for the strobed entries
//   dup      : two or more valid ports hit the same entry this cycle
// Ports are scanned in ascending order so the highest index wins a collision.
module qu_rob_wb_merge #(
    parameter int DEPTH   = 8,
    parameter int NUM_WB  = 2,
    parameter int AW      = $clog2(DEPTH),
    parameter int VALUE_W = 32,
    parameter int PC_W    = 12
) (
    input  logic [NUM_WB-1:0]               wb_valid,
    input  logic [NUM_WB*AW-1:0]            wb_addr,
    input  logic [NUM_WB*VALUE_W-1:0]       wb_value,
    input  logic [NUM_WB-1:0]               wb_mispredict,
    input  logic [NUM_WB*PC_W-1:0]          wb_pc_new,
    output logic [DEPTH-1:0]                we,
    output logic [DEPTH-1:0][VALUE_W-1:0]   value,
    output logic [DEPTH-1:0]                mispredict,
    output logic [DEPTH-1:0][PC_W-1:0]      pc_new,
    output logic                            dup
);

    always_comb begin
        we         = '0;
        value      = '0;
        mispredict = '0;
        pc_new     = '0;
        dup        = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i]) begin
                if (we[wb_addr[i*AW +: AW]])
                    dup = 1'b1;
                we[wb_addr[i*AW +: AW]]         = 1'b1;
                value[wb_addr[i*AW +: AW]]      = wb_value[i*VALUE_W +: VALUE_W];
                mispredict[wb_addr[i*AW +: AW]] = wb_mispredict[i];
                pc_new[wb_addr[i*AW +: AW]]     = wb_pc_new[i*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: rtl/qu_rob.sv
// qu_rob: circular reorder buffer for the Qu out-of-order core.
//   alloc_*   : dispatch handshake; alloc_addr is the entry given to the
//               current request (the tail).
//   wb_*      : NUM_WB write-back ports; only PENDING entries accept results.
//   retire_*  : in-order retire handshake, combinational from the head entry.
//   flush     : pulses when a mispredicted head retires; the whole buffer
//               empties at that edge.
//   count / empty / full : occupancy.
module qu_rob
    import qu_rob_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int NUM_WB  = ROB_NUM_WB,
    parameter int AW      = $clog2(DEPTH),
    parameter int VALUE_W = 32,
    parameter int PC_W    = 12,
    parameter int PREG_W  = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [AW-1:0]              alloc_addr,
    input  logic [31:0]                alloc_dest,
    input  logic [PREG_W-1:0]          alloc_phyreg_old,
    input  logic                       alloc_load,
    input  logic                       alloc_store,
    input  logic [2:0]                 alloc_funct3,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*AW-1:0]       wb_addr,
    input  logic [NUM_WB*VALUE_W-1:0]  wb_value,
    input  logic [NUM_WB-1:0]          wb_mispredict,
    input  logic [NUM_WB*PC_W-1:0]     wb_pc_new,
    output logic                       retire_valid,
    input  logic                       retire_ready,
    output logic [VALUE_W-1:0]         retire_value,
    output logic [31:0]                retire_dest,
    output logic [PREG_W-1:0]          retire_phyreg_old,
    output logic                       retire_load,
    output logic                       retire_store,
    output logic [2:0]                 retire_funct3,
    output logic [PC_W-1:0]            retire_pc_new,
    output logic                       flush,
    output logic [AW:0]                count,
    output logic                       empty,
    output logic                       full
);

    typedef struct packed {
        logic [1:0]         state;
        logic [VALUE_W-1:0] value;
        dest_t              dest;
        logic [PREG_W-1:0]  phyreg_old;
        logic               load;
        logic               store;
        logic [2:0]         funct3;
        logic               mispredicted_branch;
        logic [PC_W-1:0]    pc_new;
    } cell_t;

    cell_t           cells [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count_q;

    logic [DEPTH-1:0]              wb_we;
    logic [DEPTH-1:0][VALUE_W-1:0] wb_val;
    logic [DEPTH-1:0]              wb_mis;
    logic [DEPTH-1:0][PC_W-1:0]    wb_pc;
    logic                          wb_dup;

    cell_t head_cell;
    logic  head_flush;
    logic  alloc_fire;
    logic  retire_fire;

    qu_rob_wb_merge #(
        .DEPTH   (DEPTH),
        .NUM_WB  (NUM_WB),
        .AW      (AW),
        .VALUE_W (VALUE_W),
        .PC_W    (PC_W)
    ) u_wb_merge (
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_value      (wb_value),
        .wb_mispredict (wb_mispredict),
        .wb_pc_new     (wb_pc_new),
        .we            (wb_we),
        .value         (wb_val),
        .mispredict    (wb_mis),
        .pc_new        (wb_pc),
        .dup           (wb_dup)
    );

    assign head_cell  = cells[head];
    assign head_flush = rob_retirable(head_cell.state) & head_cell.mispredicted_branch;

    assign full        = count_q == (AW+1)'(DEPTH);
    assign empty       = count_q == '0;
    assign count       = count_q;
    // No full-bypass: a same-cycle retire does not open a slot for allocate.
    assign alloc_ready = !full & !head_flush;
    assign alloc_addr  = tail;
    assign alloc_fire  = alloc_valid & alloc_ready;

    assign retire_valid      = rob_retirable(head_cell.state);
    assign retire_fire       = retire_valid & retire_ready;
    assign flush             = retire_fire & head_cell.mispredicted_branch;
    assign retire_value      = head_cell.value;
    assign retire_dest       = head_cell.dest;
    assign retire_phyreg_old = head_cell.phyreg_old;
    assign retire_load       = head_cell.load;
    assign retire_store      = head_cell.store;
    assign retire_funct3     = head_cell.funct3;
    assign retire_pc_new     = head_cell.pc_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++)
                cells[e] <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            // Precise flush: younger entries and this cycle's write-backs die.
            for (int e = 0; e < DEPTH; e++)
                cells[e] <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_we[e] && cells[e].state == ROB_STATE_PENDING) begin
                    cells[e].state               <= ROB_STATE_EXECUTE;
                    cells[e].value               <= wb_val[e];
                    cells[e].mispredicted_branch <= wb_mis[e];
                    cells[e].pc_new              <= wb_pc[e];
                end
            end
            // head == tail with both firing is impossible: it needs full
            // (blocks alloc) or empty (blocks retire).
            if (retire_fire) begin
                cells[head].state <= ROB_STATE_EMPTY;
                head              <= head + 1'b1;
            end
            if (alloc_fire) begin
                cells[tail].state               <= ROB_STATE_PENDING;
                cells[tail].value               <= '0;
                cells[tail].dest                <= alloc_dest;
                cells[tail].phyreg_old          <= alloc_phyreg_old;
                cells[tail].load                <= alloc_load;
                cells[tail].store               <= alloc_store;
                cells[tail].funct3              <= alloc_funct3;
                cells[tail].mispredicted_branch <= 1'b0;
                cells[tail].pc_new              <= '0;
                tail                            <= tail + 1'b1;
            end
            if (alloc_fire && !retire_fire)
                count_q <= count_q + 1'b1;
            else if (!alloc_fire && retire_fire)
                count_q <= count_q - 1'b1;
        end
    end

    // Two write-back ports aimed at one entry in a cycle is an upstream bug.
    a_no_wb_dup: assert property (@(posedge clk) disable iff (rst) !wb_dup);

endmodule
